sd_drive_arbiter: RTL and testbench

Shares the single HPS SD sector channel between `NDRV` virtual floppy drives. Each drive holds a read or write request with its LBA. The arbiter grants drives in round-robin order and drives the one-hot `sd_rd`/`sd_wr` vectors and the shared `sd_lba`. It steers `sd_buff_din` from the granted drive and tracks the `sd_ack` handshake to completion. It sits between the FDC drive models and `hps_io`, replacing the ad-hoc OR of `sd_ack` and the replicated LBA/buffer wiring.

---
 rtl/sd_drive_arbiter_pkg.sv | 33 +++
 rtl/sd_drive_arbiter_if.sv | 46 ++++
 rtl/sd_drive_arbiter_rr_pick.sv | 38 +++
 rtl/sd_drive_arbiter.sv | 154 +++++++++++++++
 tb/tb_sd_drive_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sd_drive_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_arb_pkg
// Purpose  : Shared types, widths and the round-robin step helper for the
//            SD drive arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sd_arb_pkg;

  localparam int LBA_W = 32;
  localparam int BUF_W = 8;

  // Explicit encodings so the state register keeps a fixed 2-bit layout
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_XFER = 2'd2;
  localparam logic [1:0] C_ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = C_ST_IDLE,
    REQ  = C_ST_REQ,
    XFER = C_ST_XFER,
    DONE = C_ST_DONE
  } sd_arb_state_t;

  // Next drive index after idx, wrapping modulo n
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    if (32'(idx) + 32'd1 >= 32'(n)) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_drive_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_drive_arbiter_if
// Purpose  : Bundles the drive-side request bus and the hps_io-side sector
//            channel seen by the SD drive arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_drive_arbiter_if #(
  parameter int NDRV = 4
);
  import sd_arb_pkg::*;

  // Drive side
  logic [NDRV-1:0]       drv_rd;
  logic [NDRV-1:0]       drv_wr;
  logic [NDRV*LBA_W-1:0] drv_lba;
  logic [NDRV*BUF_W-1:0] drv_buff_din;
  logic [NDRV-1:0]       drv_ack;
  logic [NDRV-1:0]       drv_done;
  logic [NDRV-1:0]       drv_err;
  // hps_io side
  logic [NDRV-1:0]       sd_rd;
  logic [NDRV-1:0]       sd_wr;
  logic [LBA_W-1:0]      sd_lba;
  logic [NDRV-1:0]       sd_ack;
  logic [BUF_W-1:0]      sd_buff_din;
  // Status
  logic                  busy;
  logic [2:0]            grant;

  // The arbiter itself
  modport slave (
    input  drv_rd, drv_wr, drv_lba, drv_buff_din, sd_ack,
    output drv_ack, drv_done, drv_err, sd_rd, sd_wr, sd_lba, sd_buff_din,
           busy, grant
  );

  // The environment: drive models plus hps_io
  modport master (
    output drv_rd, drv_wr, drv_lba, drv_buff_din, sd_ack,
    input  drv_ack, drv_done, drv_err, sd_rd, sd_wr, sd_lba, sd_buff_din,
           busy, grant
  );

endinterface
`default_nettype wire

// File: rtl/sd_drive_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotate-priority encoder. Returns the first set
//            request at or after last+1, wrapping modulo NDRV.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import sd_arb_pkg::*;
#(
  parameter int NDRV = 4
) (
  input  logic [NDRV-1:0] i_req,
  input  logic [2:0]      i_last,
  output logic            o_valid,
  output logic [2:0]      o_idx
);

  logic [2:0] w_cand;

  // Walk the ring once starting after i_last; first hit wins
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    w_cand  = i_last;
    for (int k = 0; k < NDRV; k++) begin
      w_cand = rr_next(w_cand, NDRV);
      for (int d = 0; d < NDRV; d++) begin
        if (!o_valid && (3'(d) == w_cand) && i_req[d]) begin
          o_valid = 1'b1;
          o_idx   = w_cand;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_drive_arbiter
// Purpose  : Round-robin sharing of the single HPS SD sector channel between
//            NDRV virtual floppy drives. Latches the granted LBA/operation,
//            drives one-hot sd_rd/sd_wr and follows the sd_ack handshake.
// Options  : SD_ARB_TIMEOUT_EN - adds a REQ-state watchdog that completes
//            the request with drv_err after TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NDRV           = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_400_000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  sd_drive_arbiter_if.slave   bus
);

  sd_arb_state_t     r_state;
  logic [2:0]        r_grant;
  logic [2:0]        r_last;
  logic              r_is_wr;
  logic [LBA_W-1:0]  r_sd_lba;
  logic [NDRV-1:0]   r_sd_rd;
  logic [NDRV-1:0]   r_sd_wr;
  logic              r_err;

  logic [NDRV-1:0]   w_req;
  logic              w_pick_valid;
  logic [2:0]        w_pick_idx;
  logic [LBA_W-1:0]  w_pick_lba;
  logic              w_pick_wr;
  logic [NDRV-1:0]   w_grant_oh;
  logic              w_ack_sel;
  logic [BUF_W-1:0]  w_buf_sel;
  logic              w_busy;

  assign w_req = bus.drv_rd | bus.drv_wr;

  rr_pick #(.NDRV(NDRV)) u_rr_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Per-drive selects: candidate request fields and granted-drive steering
  always_comb begin
    w_pick_lba = '0;
    w_pick_wr  = 1'b0;
    w_grant_oh = '0;
    w_ack_sel  = 1'b0;
    w_buf_sel  = '0;
    for (int d = 0; d < NDRV; d++) begin
      if (3'(d) == w_pick_idx) begin
        w_pick_lba = bus.drv_lba[d*LBA_W +: LBA_W];
        w_pick_wr  = bus.drv_wr[d];
      end
      if (3'(d) == r_grant) begin
        w_grant_oh[d] = 1'b1;
        w_ack_sel     = bus.sd_ack[d];
        w_buf_sel     = bus.drv_buff_din[d*BUF_W +: BUF_W];
      end
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] r_cnt;

  // REQ watchdog: cleared when a grant is made, counts every REQ cycle
  always_ff @(posedge clk_sys) begin
    if (!reset_n)            r_cnt <= 24'd0;
    else if (r_state == REQ) r_cnt <= r_cnt + 24'd1;
    else                     r_cnt <= 24'd0;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Arbitration FSM; a write wins over a read on the same drive
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= 3'd0;
      r_last   <= 3'(NDRV - 1);
      r_is_wr  <= 1'b0;
      r_sd_lba <= '0;
      r_sd_rd  <= '0;
      r_sd_wr  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant  <= w_pick_idx;
            r_sd_lba <= w_pick_lba;
            r_is_wr  <= w_pick_wr;
            r_err    <= 1'b0;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (w_ack_sel) begin
            r_sd_rd <= '0;
            r_sd_wr <= '0;
            r_state <= XFER;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (r_cnt + 24'd1 == TIMEOUT_CYCLES) begin
            r_sd_rd <= '0;
            r_sd_wr <= '0;
            r_err   <= 1'b1;
            r_state <= DONE;
          end
`endif
          else begin
            r_sd_rd <= r_is_wr ? '0 : w_grant_oh;
            r_sd_wr <= r_is_wr ? w_grant_oh : '0;
          end
        end
        XFER: begin
          if (!w_ack_sel) r_state <= DONE;
        end
        DONE: begin
          r_last  <= r_grant;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy          = (r_state != IDLE);
  assign bus.busy        = w_busy;
  assign bus.grant       = r_grant;
  assign bus.sd_lba      = r_sd_lba;
  assign bus.sd_rd       = r_sd_rd;
  assign bus.sd_wr       = r_sd_wr;
  assign bus.drv_ack     = (w_busy && w_ack_sel) ? w_grant_oh : '0;
  assign bus.drv_done    = (r_state == DONE) ? w_grant_oh : '0;
  assign bus.sd_buff_din = w_busy ? w_buf_sel : '0;
`ifdef SD_ARB_TIMEOUT_EN
  assign bus.drv_err     = (r_state == DONE && r_err) ? w_grant_oh : '0;
`else
  assign bus.drv_err     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_drive_arbiter
// Purpose  : Directed self-checking bench for sd_drive_arbiter (NDRV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_drive_arbiter;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always #5 clk_sys = ~clk_sys;

  sd_drive_arbiter_if #(.NDRV(4)) bus ();

  sd_drive_arbiter #(.NDRV(4), .TIMEOUT_CYCLES(24'd16)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle just past it
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.drv_rd       = '0;
    bus.drv_wr       = '0;
    bus.drv_lba      = '0;
    bus.drv_buff_din = '0;
    bus.sd_ack       = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Act as hps_io: wait for a strobe, ack it for two cycles, release, land in DONE
  task automatic serve(output logic [2:0] g, output logic [3:0] rd, output logic [3:0] wr);
    int cyc = 0;
    while (((bus.sd_rd | bus.sd_wr) == 4'd0) && cyc < 20) begin
      tick();
      cyc++;
    end
    if ((bus.sd_rd | bus.sd_wr) == 4'd0) chk("serve_strobe_wait", 32'd0, 32'd1);
    g  = bus.grant;
    rd = bus.sd_rd;
    wr = bus.sd_wr;
    bus.sd_ack = rd | wr;
    tick();
    tick();
    bus.sd_ack = '0;
    tick();
  endtask

  logic [2:0] g;
  logic [3:0] rd, wr;

  initial begin
    // ---- reset state and single read on drive 2 ----
    do_reset();
    chk("rst_sd_rd", 32'(bus.sd_rd), 32'h0);
    chk("rst_sd_wr", 32'(bus.sd_wr), 32'h0);
    chk("rst_sd_lba", bus.sd_lba, 32'h0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.drv_done), 32'h0);
    bus.drv_lba[2*32 +: 32] = 32'h1234;
    bus.drv_rd[2]           = 1'b1;
    tick();
    chk("t1_busy_after_grant", 32'(bus.busy), 32'h1);
    chk("t1_rd_not_yet", 32'(bus.sd_rd), 32'h0);
    tick();
    chk("t1_sd_rd", 32'(bus.sd_rd), 32'b0100);
    chk("t1_sd_lba", bus.sd_lba, 32'h1234);
    bus.sd_ack                 = 4'b0100;
    bus.drv_buff_din[2*8 +: 8] = 8'hA5;
    tick();
    chk("t1_rd_dropped", 32'(bus.sd_rd), 32'h0);
    chk("t1_drv_ack", 32'(bus.drv_ack), 32'b0100);
    chk("t1_buff_a5", 32'(bus.sd_buff_din), 32'hA5);
    bus.drv_buff_din[2*8 +: 8] = 8'h5A;
    #1;
    chk("t1_buff_comb", 32'(bus.sd_buff_din), 32'h5A);
    tick();
    tick();
    chk("t1_no_early_done", 32'(bus.drv_done), 32'h0);
    bus.sd_ack = '0;
    tick();
    chk("t1_done", 32'(bus.drv_done), 32'b0100);
    bus.drv_rd = '0;
    tick();
    chk("t1_done_single", 32'(bus.drv_done), 32'h0);
    chk("t1_idle", 32'(bus.busy), 32'h0);
    chk("t1_buff_idle", 32'(bus.sd_buff_din), 32'h0);
    chk("t1_grant_hold", 32'(bus.grant), 32'd2);

    // ---- round robin with all drives reading ----
    do_reset();
    bus.drv_rd = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(g, rd, wr);
      chk("rr_grant", 32'(g), 32'(i % 4));
      chk("rr_sd_rd", 32'(rd), 32'(4'b0001 << (i % 4)));
      chk("rr_done", 32'(bus.drv_done), 32'(4'b0001 << (i % 4)));
      tick();
    end
    bus.drv_rd = '0;
    tick();

    // ---- write beats read on the same drive ----
    do_reset();
    bus.drv_wr[1] = 1'b1;
    bus.drv_rd[1] = 1'b1;
    serve(g, rd, wr);
    chk("wr_first_sd_wr", 32'(wr), 32'b0010);
    chk("wr_first_sd_rd", 32'(rd), 32'h0);
    chk("wr_first_done", 32'(bus.drv_done), 32'b0010);
    bus.drv_wr[1] = 1'b0;
    tick();
    serve(g, rd, wr);
    chk("rd_next_sd_rd", 32'(rd), 32'b0010);
    chk("rd_next_sd_wr", 32'(wr), 32'h0);
    chk("rd_next_grant", 32'(g), 32'd1);
    bus.drv_rd = '0;
    tick();

    // ---- stray acks and LBA freeze ----
    do_reset();
    bus.sd_ack = 4'b1111;
    tick();
    chk("idle_ack_ignored", 32'(bus.busy), 32'h0);
    chk("idle_drv_ack", 32'(bus.drv_ack), 32'h0);
    bus.sd_ack               = '0;
    bus.drv_lba[0 +: 32]     = 32'hAAAA_0000;
    bus.drv_rd[0]            = 1'b1;
    tick();
    bus.drv_lba[0 +: 32] = 32'hBBBB_0000;
    tick();
    chk("frz_sd_rd", 32'(bus.sd_rd), 32'b0001);
    chk("frz_sd_lba", bus.sd_lba, 32'hAAAA_0000);
    bus.sd_ack = 4'b1000;
    tick();
    chk("other_ack_rd_held", 32'(bus.sd_rd), 32'b0001);
    chk("other_ack_drv_ack", 32'(bus.drv_ack), 32'h0);
    bus.sd_ack = 4'b1001;
    tick();
    chk("own_ack_rd_drop", 32'(bus.sd_rd), 32'h0);
    bus.sd_ack = 4'b1000;
    tick();
    chk("other_ack_xfer_done", 32'(bus.drv_done), 32'b0001);
    chk("frz_lba_at_done", bus.sd_lba, 32'hAAAA_0000);
    bus.drv_rd = '0;
    bus.sd_ack = '0;
    tick();

    // ---- reset during XFER ----
    do_reset();
    bus.drv_lba[3*32 +: 32] = 32'hCAFE;
    bus.drv_rd[3]           = 1'b1;
    tick();
    tick();
    chk("rx_sd_rd", 32'(bus.sd_rd), 32'b1000);
    bus.sd_ack = 4'b1000;
    tick();
    chk("rx_in_xfer", 32'(bus.busy), 32'h1);
    reset_n = 1'b0;
    tick();
    chk("rx_busy", 32'(bus.busy), 32'h0);
    chk("rx_grant", 32'(bus.grant), 32'h0);
    chk("rx_lba", bus.sd_lba, 32'h0);
    chk("rx_ack", 32'(bus.drv_ack), 32'h0);
    bus.sd_ack = '0;
    bus.drv_rd = '0;
    reset_n    = 1'b1;
    tick();
    chk("rx_no_done", 32'(bus.drv_done), 32'h0);

`ifdef SD_ARB_TIMEOUT_EN
    // ---- watchdog in REQ ----
    begin
      int cyc = 0;
      do_reset();
      bus.drv_rd[1] = 1'b1;
      tick();
      while (bus.drv_done == 4'd0 && cyc < 40) begin
        tick();
        cyc++;
      end
      chk("to_cycles", 32'(cyc), 32'd16);
      chk("to_done", 32'(bus.drv_done), 32'b0010);
      chk("to_err", 32'(bus.drv_err), 32'b0010);
      chk("to_rd_dropped", 32'(bus.sd_rd), 32'h0);
      bus.drv_rd = 4'b0100;
      tick();
      serve(g, rd, wr);
      chk("to_next_grant", 32'(g), 32'd2);
      chk("to_next_err", 32'(bus.drv_err), 32'h0);
      bus.drv_rd = '0;
      tick();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
